// File: rtl/fifo_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_reader_if
// Purpose  : Bundles the FIFO read port (pop request, empty flag, read data)
//            and the downstream valid/ready stream of fifo_burst_reader.
// Modports : master - the reader: drives fifo_en_read and the m_* stream,
//                     samples fifo_empty, fifo_rdata and m_ready.
//            slave  - the environment (FIFO plus stream sink).
// Signals  : fifo_empty    FIFO empty flag
//            fifo_rdata    FIFO read data, valid the cycle after a pop
//            fifo_en_read  FIFO pop request
//            m_valid       output word valid
//            m_ready       downstream accepts word
//            m_data        output word
//            m_last        last word of burst, qualified by m_valid
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_burst_reader_if #(
  parameter int DATAWIDTH = 8
);
  logic                 fifo_empty;
  logic [DATAWIDTH-1:0] fifo_rdata;
  logic                 fifo_en_read;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATAWIDTH-1:0] m_data;
  logic                 m_last;

  modport master (
    input  fifo_empty, fifo_rdata, m_ready,
    output fifo_en_read, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_rdata, m_ready,
    input  fifo_en_read, m_valid, m_data, m_last
  );
endinterface
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_reader
// Purpose  : Read-side controller for a synchronous FIFO. Pops words and
//            presents them on a valid/ready stream, flagging every
//            BURST_LEN-th delivered word with m_last. A 2-entry buffer hides
//            the FIFO's 1-cycle read latency so 1 word/cycle is sustained.
// Ports    : clk        clock, all state on rising edge
//            reset      asynchronous, active-high
//            enable     1 = fetch from FIFO, 0 = stop fetching and drain
//            bus        fifo_burst_reader_if.master (FIFO port + stream)
//            busy       controller not IDLE
//            word_count delivered-word count, saturating at 16'hFFFF
//                       (present only with FIFO_READER_WORD_COUNT_EN)
// Options  : `define FIFO_READER_WORD_COUNT_EN to add the word_count port.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
  parameter int DATAWIDTH = 8,
  parameter int BURST_LEN = 4
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              enable,
  fifo_burst_reader_if.master    bus,
  output logic                   busy
`ifdef FIFO_READER_WORD_COUNT_EN
  ,
  output logic [15:0]            word_count
`endif
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [1:0]           occ;        // words held in the buffer (0..2)
  logic                 inflight;   // a popped word arrives on fifo_rdata next edge
  logic [DATAWIDTH-1:0] buf0;       // buffer head, drives m_data
  logic [DATAWIDTH-1:0] buf1;
  logic [7:0]           beat;

  logic                 m_valid;
  logic                 pop;
  logic                 en_read;
  logic [2:0]           pending;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && bus.m_ready;

  // Words that will be buffered after this edge without a new fetch. A new
  // pop may only be issued if that leaves room for its data, which keeps
  // the buffer at two entries or fewer.
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  assign bus.fifo_en_read = en_read;
  assign bus.m_valid      = m_valid;
  assign bus.m_data       = buf0;
  // Gated by m_valid so a single-word burst does not flag m_last while idle.
  assign bus.m_last       = m_valid && (beat == LAST_BEAT);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    en_read   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_nxt = DRAIN;
        end else if (!bus.fifo_empty && (pending <= 3'd1)) begin
          en_read = 1'b1;
        end
      end
      DRAIN: begin
        // The word already in flight is still captured before leaving.
        if (enable) begin
          state_nxt = RUN;
        end else if ((occ == 2'd0) && !inflight) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
      beat     <= 8'd0;
    end else begin
      inflight <= en_read;

      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= bus.fifo_rdata;
          else             buf1 <= bus.fifo_rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind the new head.
          if (occ == 2'd2) begin
            buf0 <= buf1;
            buf1 <= bus.fifo_rdata;
          end else begin
            buf0 <= bus.fifo_rdata;
          end
        end
        default: ;
      endcase

      // Beat tracks delivered words, so m_last follows delivery order and
      // survives enable toggling.
      if (pop) begin
        beat <= (beat == LAST_BEAT) ? 8'd0 : beat + 8'd1;
      end
    end
  end

`ifdef FIFO_READER_WORD_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count <= 16'd0;
    end else if (pop && (word_count != 16'hFFFF)) begin
      word_count <= word_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
